// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl (with local subtractor)
// Description : Multi-cycle unsigned restoring divider; one trial subtraction
//               per clock, quotient/remainder presented with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================

module subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    assign {bout, diff} = {1'b0, a} - {1'b0, b};
endmodule

module div_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int          c_CNT_W      = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_COUNT_INIT = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_dvsr;
    logic [c_CNT_W-1:0]   r_count;

    logic [WIDTH-1:0]     w_s;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_bout;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_q_nxt;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign w_s       = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_rem_nxt = w_bout ? w_s : w_diff;
    assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_bout};

    subtractor #(.WIDTH(WIDTH)) u_sub (
        .a    (w_s),
        .b    (r_dvsr),
        .diff (w_diff),
        .bout (w_bout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_dvsr      <= '0;
            r_count     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q     <= dividend;
                        r_dvsr  <= divisor;
                        r_rem   <= '0;
                        r_count <= c_COUNT_INIT;
                        if (divisor == '0) begin
                            quotient    <= {WIDTH{1'b1}};
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_rem   <= w_rem_nxt;
                    r_q     <= w_q_nxt;
                    r_count <= r_count - 1'b1;
                    // Last iteration: publish results on the same edge.
                    if (r_count == '0) begin
                        quotient    <= w_q_nxt;
                        remainder   <= w_rem_nxt;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq_ctrl
// Description : Self-checking bench for div_seq_ctrl against a timing/arith
//               reference model using plain division and modulo.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_div_seq_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int total;
    int bad;

    // Reference model: cycles of busy left, done flag, published results.
    int       m_run_left;
    bit       m_done;
    bit [7:0] m_q;
    bit [7:0] m_r;
    bit       m_z;
    bit [7:0] p_q;
    bit [7:0] p_r;

    div_seq_ctrl #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_run_left = 0;
            m_done     = 0;
            m_q = 0; m_r = 0; m_z = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_run_left > 0) begin
            m_run_left--;
            if (m_run_left == 0) begin
                m_done = 1;
                m_q = p_q; m_r = p_r; m_z = 0;
            end
        end else if (start) begin
            if (divisor == 0) begin
                m_done = 1;
                m_q = 8'hFF; m_r = dividend; m_z = 1;
            end else begin
                m_run_left = 8;
                p_q = dividend / divisor;
                p_r = dividend % divisor;
            end
        end
    endtask

    // One clock: advance model on the edge, then compare every output.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy",        busy,        m_run_left > 0);
        chk("done",        done,        m_done);
        chk("quotient",    quotient,    m_q);
        chk("remainder",   remainder,   m_r);
        chk("div_by_zero", div_by_zero, m_z);
    endtask

    // Directed op with literal expected results and latency.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input bit ez);
        int n;
        start = 1; dividend = a; divisor = b;
        step();
        start = 0; dividend = $urandom; divisor = $urandom;
        n = 1;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk("op_timeout",   done, 1);
        chk("op_latency",   n, (b == 0) ? 1 : 9);
        chk("op_quotient",  quotient, eq);
        chk("op_remainder", remainder, er);
        chk("op_dbz",       div_by_zero, ez);
        chk("model_q_pin",  m_q, eq);
        chk("model_r_pin",  m_r, er);
        step();
    endtask

    initial begin
        int n;
        int dones;
        logic [7:0] a;
        logic [7:0] b;
        total = 0; bad = 0;
        m_run_left = 0; m_done = 0; m_q = 0; m_r = 0; m_z = 0; p_q = 0; p_r = 0;
        rst_n = 0; start = 0; dividend = 0; divisor = 0;

        step(); step();
        chk("rst_quotient", quotient, 0);
        chk("rst_busy",     busy, 0);
        rst_n = 1;
        step();

        do_op(200, 7, 28, 4, 0);
        do_op(255, 1, 255, 0, 0);
        do_op(13, 200, 0, 13, 0);
        do_op(255, 255, 1, 0, 0);
        do_op(77, 0, 8'hFF, 77, 1);

        // start held high across an operation and its DONE cycle
        start = 1; dividend = 100; divisor = 9;
        step();
        dividend = 50; divisor = 5;
        dones = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (done) begin
                dones++;
                chk("hold_q", quotient, 11);
                chk("hold_r", remainder, 1);
            end
        end
        chk("hold_dones", dones, 1);
        step();
        chk("hold_reaccept_busy", busy, 1);
        start = 0;
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk("hold2_latency", n, 8);
        chk("hold2_q", quotient, 10);
        chk("hold2_r", remainder, 0);
        step();

        // reset in the middle of a run
        start = 1; dividend = 200; divisor = 7;
        step();
        start = 0;
        step(); step(); step();
        rst_n = 0;
        step();
        rst_n = 1;
        chk("midrst_q",    quotient, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        for (int i = 0; i < 10; i++) step();
        do_op(9, 3, 3, 0, 0);

        // randomized sweep, with junk on the inputs while busy
        for (int t = 0; t < 2000; t++) begin
            a = $urandom;
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            start = 1; dividend = a; divisor = b;
            step();
            n = 1;
            while (!done && n < 20) begin
                start = $urandom_range(0, 1);
                dividend = $urandom; divisor = $urandom;
                step();
                n++;
            end
            chk("rnd_timeout", done, 1);
            if (b == 0) begin
                chk("rnd_dbz_flag", div_by_zero, 1);
                chk("rnd_dbz_q",    quotient, 8'hFF);
                chk("rnd_dbz_r",    remainder, a);
            end else begin
                chk("rnd_flag",      div_by_zero, 0);
                chk("rnd_invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                chk("rnd_rem_lt",    remainder < b, 1);
            end
            start = 0;
            step();
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle unsigned 8-bit restoring divider controller for the ALU.
- Owns one instance of the team's 8-bit `subtractor` (a - b, borrow-out `bout`) and issues one trial subtraction per clock.
- Sequences shift / trial-subtract / restore over 8 iterations and presents quotient and remainder with a done pulse.
- Sits beside the combinational ALU ops; the ALU top issues `start` and reads results.

Parameters:
- WIDTH, 8, operand/result width; fixed to 8 to match the `subtractor` instance; other values unsupported.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- dividend  input  8  unsigned dividend; captured on accepted start.
- divisor  input  8  unsigned divisor; captured on accepted start.
- busy  output  1  high while an operation is in progress (state RUN).
- done  output  1  one-cycle pulse; results valid.
- quotient  output  8  unsigned quotient.
- remainder  output  8  unsigned remainder.
- div_by_zero  output  1  set with done when captured divisor == 0.

Behaviour:
- Reset, sampled low on a rising edge:
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - All internal registers (rem, q, dvsr, count) cleared.
  - Takes priority over every other event, including mid-RUN; the in-flight operation is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, capture dividend into q, divisor into dvsr, and clear rem to 0.
  - If divisor==0, go to DONE with the div-by-zero result; otherwise go to RUN with count=7.
  - With start=0, stay in IDLE.
- RUN, one iteration per cycle:
  - Form s = {rem[6:0], q[7]}.
  - Subtractor inputs: a=s, b=dvsr.
  - bout==0: rem<=diff, q<={q[6:0],1}.
  - bout==1: rem<=s, q<={q[6:0],0}.
  - The shifted partial s always fits 8 bits because rem never exceeds the dividend prefix consumed so far. No 9th bit is required.
  - count decrements each cycle; at count==0, complete the iteration and go to DONE.
  - quotient and remainder load from the final q and rem on this same edge; div_by_zero<=0.
- DONE:
  - done=1 for exactly one cycle, busy=0, then go to IDLE unconditionally.
  - start during DONE is ignored.
- Div-by-zero path, loaded on the IDLE->DONE edge:
  - quotient<=8'hFF, remainder<=captured dividend, div_by_zero<=1.
- Latency: start accepted at edge k.
  - Normal: busy=1 in cycles k+1..k+8, done=1 in cycle k+9. Earliest next accepted start is edge k+10.
  - Div-by-zero: done=1 in cycle k+1, busy stays 0.
- Result holding:
  - quotient, remainder and div_by_zero change only on entry to DONE (or on reset).
  - They hold their values through IDLE and the next RUN until the next completion.
- Input stability:
  - start and operand changes while busy or in DONE have no effect.
  - Operands are read only at acceptance.
- Arithmetic:
  - Unsigned throughout.
  - Invariant at DONE: dividend == quotient*divisor + remainder, remainder < divisor.
- `busy` and `done` are registered, state-decoded outputs with no combinational path from `start`.

Test Plan:
- Reset 2 cycles, then start with dividend=200, divisor=7 -> busy high for 8 cycles; done in cycle k+9 with quotient=28, remainder=4, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. dividend=13, divisor=200 -> quotient=0, remainder=13. dividend=255, divisor=255 -> quotient=1, remainder=0.
- dividend=77, divisor=0 -> done in cycle k+1 with div_by_zero=1, quotient=8'hFF, remainder=77, busy never asserted.
- Start 100/9 at edge k, then hold start=1 with operands 50/5 through cycle k+9 -> single done with quotient=11, remainder=1. start still high at edge k+10 -> new op accepted, done at k+19 with quotient=10, remainder=0.
- Start 200/7, then assert rst_n=0 at cycle k+4 for one edge -> all outputs 0 next cycle, no done pulse. A fresh start 9/3 then completes with quotient=3, remainder=0.
- Random sweep of 2000 operand pairs including divisor 0 -> every done satisfies the invariant, or the div-by-zero rule when divisor=0. done is exactly one cycle, and results are stable between completions.
